// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - data-memory initiator: load, store and forward byte copy
// Address range is checked before every access; an out-of-range address aborts to DONE with Error.
module dmem_access_ctrl #(
   parameter int         MEM_DEPTH   = 32,
   parameter logic [2:0] WRITE_PHASE = 3'd3
) (
   input  logic       Clk,
   input  logic       Clear_n,
   input  logic       Start,
   input  logic [1:0] Cmd,
   input  logic [7:0] Src_Addr,
   input  logic [7:0] Dst_Addr,
   input  logic [5:0] Length,
   input  logic [7:0] Store_Data,
   output logic       Busy,
   output logic       Done,
   output logic       Error,
   output logic [7:0] Load_Data,
   output logic [2:0] Mem_State,
   output logic [7:0] Mem_Address,
   output logic [7:0] Mem_Write_Data,
   input  logic [7:0] Mem_Read_Data,
   output logic       MemRead,
   output logic       MemWrite
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   localparam logic [1:0] CMD_LOAD  = 2'b00;
   localparam logic [1:0] CMD_STORE = 2'b01;
   localparam logic [1:0] CMD_COPY  = 2'b10;

   state_t     state_q, state_d;
   logic [1:0] cmd_q, cmd_d;
   logic [7:0] src_q, src_d;
   logic [7:0] dst_q, dst_d;
   logic [5:0] len_q, len_d;
   logic [7:0] data_q, data_d;
   logic [5:0] idx_q, idx_d;
   logic       err_q, err_d;
   logic [7:0] load_q, load_d;

   logic [5:0] idx_inc;
   logic [7:0] rd_addr, wr_addr, next_rd_addr;

   function automatic logic in_range(input logic [7:0] a);
      return ({24'd0, a} < 32'(MEM_DEPTH));
   endfunction

   assign idx_inc      = idx_q + 6'd1;
   assign rd_addr      = src_q + {2'b00, idx_q};
   assign wr_addr      = dst_q + {2'b00, idx_q};
   assign next_rd_addr = src_q + {2'b00, idx_inc};

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      data_d  = data_q;
      idx_d   = idx_q;
      err_d   = err_q;
      load_d  = load_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               cmd_d  = Cmd;
               src_d  = Src_Addr;
               dst_d  = Dst_Addr;
               len_d  = Length;
               data_d = Store_Data;
               idx_d  = 6'd0;
               err_d  = 1'b0;
               state_d = S_DONE;
               case (Cmd)
                  CMD_LOAD: begin
                     if (in_range(Src_Addr)) state_d = S_READ;
                     else                    err_d   = 1'b1;
                  end
                  CMD_STORE: begin
                     if (in_range(Dst_Addr)) state_d = S_WRITE;
                     else                    err_d   = 1'b1;
                  end
                  CMD_COPY: begin
                     if (Length != 6'd0) begin
                        if (in_range(Src_Addr)) state_d = S_READ;
                        else                    err_d   = 1'b1;
                     end
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         S_READ: begin
            if (cmd_q == CMD_LOAD) begin
               load_d  = Mem_Read_Data;
               state_d = S_DONE;
            end else begin
               data_d = Mem_Read_Data;
               if (in_range(wr_addr)) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end
            end
         end
         S_WRITE: begin
            state_d = S_DONE;
            if (cmd_q == CMD_COPY) begin
               idx_d = idx_inc;
               // Range check of the next source byte happens before READ is entered
               if (idx_inc != len_q) begin
                  if (in_range(next_rd_addr)) state_d = S_READ;
                  else                        err_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Clear_n) begin
      if (!Clear_n) begin
         state_q <= S_IDLE;
         cmd_q   <= 2'b00;
         src_q   <= 8'd0;
         dst_q   <= 8'd0;
         len_q   <= 6'd0;
         data_q  <= 8'd0;
         idx_q   <= 6'd0;
         err_q   <= 1'b0;
         load_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         load_q  <= load_d;
      end
   end

   // Memory-side outputs decode straight from the state so reset removes them at once
   always_comb begin
      Mem_State      = 3'd0;
      Mem_Address    = 8'd0;
      Mem_Write_Data = 8'd0;
      MemRead        = 1'b0;
      MemWrite       = 1'b0;
      case (state_q)
         S_READ: begin
            Mem_State   = 3'd2;
            Mem_Address = rd_addr;
            MemRead     = 1'b1;
         end
         S_WRITE: begin
            Mem_State      = WRITE_PHASE;
            Mem_Address    = (cmd_q == CMD_COPY) ? wr_addr : dst_q;
            Mem_Write_Data = data_q;
            MemWrite       = 1'b1;
         end
         S_DONE:  Mem_State = 3'd4;
         default: Mem_State = 3'd0;
      endcase
   end

   assign Busy      = (state_q != S_IDLE);
   assign Done      = (state_q == S_DONE);
   assign Error     = Done & err_q;
   assign Load_Data = load_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed vector bench for dmem_access_ctrl with a 32-byte memory model
module tb_dmem_access_ctrl;

   logic       Clk = 1'b0;
   logic       Clear_n = 1'b0;
   logic       Start = 1'b0;
   logic [1:0] Cmd = 2'b00;
   logic [7:0] Src_Addr = 8'd0;
   logic [7:0] Dst_Addr = 8'd0;
   logic [5:0] Length = 6'd0;
   logic [7:0] Store_Data = 8'd0;
   logic       Busy, Done, Error, MemRead, MemWrite;
   logic [7:0] Load_Data, Mem_Address, Mem_Write_Data, Mem_Read_Data;
   logic [2:0] Mem_State;

   logic [7:0] mem [32];
   logic       mem_load = 1'b1;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         viol = 0;

   always #5 Clk = ~Clk;

   dmem_access_ctrl dut (
      .Clk(Clk), .Clear_n(Clear_n), .Start(Start), .Cmd(Cmd),
      .Src_Addr(Src_Addr), .Dst_Addr(Dst_Addr), .Length(Length), .Store_Data(Store_Data),
      .Busy(Busy), .Done(Done), .Error(Error), .Load_Data(Load_Data),
      .Mem_State(Mem_State), .Mem_Address(Mem_Address), .Mem_Write_Data(Mem_Write_Data),
      .Mem_Read_Data(Mem_Read_Data), .MemRead(MemRead), .MemWrite(MemWrite)
   );

   assign Mem_Read_Data = (Mem_Address < 8'd32) ? mem[Mem_Address[4:0]] : 8'h00;

   always @(posedge Clk) begin
      if (mem_load) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'(i);
         mem[16] <= 8'h00;
         for (int i = 17; i < 32; i++) mem[i] <= 8'(8'hff - 8'(i - 17));
      end else if (MemWrite && Mem_State == 3'd3 && Mem_Address < 8'd32) begin
         mem[Mem_Address[4:0]] <= Mem_Write_Data;
      end
   end

   always @(negedge Clk) begin
      if (Clear_n) begin
         if (MemRead && MemWrite) viol++;
         if (MemWrite != (Mem_State == 3'd3)) viol++;
         if (MemRead != (Mem_State == 3'd2)) viol++;
         if ((MemRead || MemWrite) && Mem_Address >= 8'd32) viol++;
         if (!MemRead && !MemWrite && (Mem_Address != 8'd0 || Mem_Write_Data != 8'd0)) viol++;
         if (Error && !Done) viol++;
         if (Done && !Busy) viol++;
      end
   end

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   typedef struct {
      logic [1:0] cmd;
      logic [7:0] src;
      logic [7:0] dst;
      logic [5:0] len;
      logic [7:0] data;
      int         cyc;
      logic       err;
      int         rd;
      int         wr;
      logic [7:0] ld;
   } vec_t;

   vec_t vt[17];

   task automatic issue(input logic [1:0] c, input logic [7:0] s, input logic [7:0] d,
                        input logic [5:0] l, input logic [7:0] sd);
      @(negedge Clk);
      Cmd = c; Src_Addr = s; Dst_Addr = d; Length = l; Store_Data = sd;
      Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
   endtask

   task automatic run_cmd(input vec_t v, output int cyc, output logic err,
                          output int nrd, output int nwr);
      issue(v.cmd, v.src, v.dst, v.len, v.data);
      cyc = -1; err = 1'b0; nrd = 0; nwr = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge Clk);
         if (MemRead) nrd++;
         if (MemWrite) nwr++;
         if (Done) begin
            cyc = c;
            err = Error;
            break;
         end
      end
   endtask

   initial begin
      int   cyc, nrd, nwr;
      logic err;
      logic [7:0] saved;

      vt[0]  = '{2'b00, 8'd17, 8'd0,  6'd0, 8'h00, 2, 1'b0, 1, 0, 8'hff};
      vt[1]  = '{2'b01, 8'd0,  8'd3,  6'd0, 8'ha5, 2, 1'b0, 0, 1, 8'hff};
      vt[2]  = '{2'b00, 8'd3,  8'd0,  6'd0, 8'h00, 2, 1'b0, 1, 0, 8'ha5};
      vt[3]  = '{2'b10, 8'd16, 8'd0,  6'd4, 8'h00, 9, 1'b0, 4, 4, 8'ha5};
      vt[4]  = '{2'b00, 8'd1,  8'd0,  6'd0, 8'h00, 2, 1'b0, 1, 0, 8'hff};
      vt[5]  = '{2'b00, 8'd40, 8'd0,  6'd0, 8'h00, 1, 1'b1, 0, 0, 8'hff};
      vt[6]  = '{2'b11, 8'd0,  8'd0,  6'd0, 8'h00, 1, 1'b1, 0, 0, 8'hff};
      vt[7]  = '{2'b10, 8'd30, 8'd0,  6'd4, 8'h00, 5, 1'b1, 2, 2, 8'hff};
      vt[8]  = '{2'b00, 8'd0,  8'd0,  6'd0, 8'h00, 2, 1'b0, 1, 0, 8'hf2};
      vt[9]  = '{2'b00, 8'd1,  8'd0,  6'd0, 8'h00, 2, 1'b0, 1, 0, 8'hf1};
      vt[10] = '{2'b00, 8'd2,  8'd0,  6'd0, 8'h00, 2, 1'b0, 1, 0, 8'hfe};
      vt[11] = '{2'b10, 8'd5,  8'd9,  6'd0, 8'h00, 1, 1'b0, 0, 0, 8'hfe};
      vt[12] = '{2'b01, 8'd0,  8'd40, 6'd0, 8'h11, 1, 1'b1, 0, 0, 8'hfe};
      vt[13] = '{2'b10, 8'd0,  8'd31, 6'd3, 8'h00, 4, 1'b1, 2, 1, 8'hfe};
      vt[14] = '{2'b00, 8'd31, 8'd0,  6'd0, 8'h00, 2, 1'b0, 1, 0, 8'hf2};
      vt[15] = '{2'b10, 8'd0,  8'd1,  6'd3, 8'h00, 7, 1'b0, 3, 3, 8'hf2};
      vt[16] = '{2'b00, 8'd3,  8'd0,  6'd0, 8'h00, 2, 1'b0, 1, 0, 8'hf2};

      repeat (2) @(posedge Clk);
      mem_load = 1'b0;
      #1;
      chk("rst_busy", int'(Busy), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_error", int'(Error), 0);
      chk("rst_memrw", int'({MemRead, MemWrite}), 0);
      chk("rst_mem_state", int'(Mem_State), 0);
      chk("rst_addr_wdata", int'({Mem_Address, Mem_Write_Data}), 0);
      chk("rst_load_data", int'(Load_Data), 0);
      @(negedge Clk);
      Clear_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         run_cmd(vt[i], cyc, err, nrd, nwr);
         chk($sformatf("v%0d_done_cycle", i), cyc, vt[i].cyc);
         chk($sformatf("v%0d_error", i), int'(err), int'(vt[i].err));
         chk($sformatf("v%0d_reads", i), nrd, vt[i].rd);
         chk($sformatf("v%0d_writes", i), nwr, vt[i].wr);
         chk($sformatf("v%0d_load_data", i), int'(Load_Data), int'(vt[i].ld));
      end
      chk("mem2_untouched_by_err_copy", int'(mem[2]), 8'hf2);
      chk("mem31_from_copy", int'(mem[31]), 8'hf2);

      // Start pulsed mid-copy must be ignored
      saved = mem[20];
      issue(2'b10, 8'd4, 8'd8, 6'd2, 8'h00);
      cyc = -1; nwr = 0;
      for (int c = 1; c <= 50; c++) begin
         @(negedge Clk);
         if (c == 1) chk("busy_after_start", int'(Busy), 1);
         if (MemWrite) nwr++;
         if (Done) begin
            cyc = c;
            break;
         end
         if (c == 2) begin
            Cmd = 2'b01; Dst_Addr = 8'd20; Store_Data = 8'h77; Start = 1'b1;
            @(posedge Clk);
            #1 Start = 1'b0;
         end
      end
      chk("busy_start_done_cycle", cyc, 5);
      chk("busy_start_writes", nwr, 2);
      @(negedge Clk);
      chk("idle_after_done", int'({Busy, Done}), 0);
      chk("ignored_store_target", int'(mem[20]), int'(saved));
      chk("copy_mem8_mem9", int'({mem[8], mem[9]}), 16'h0405);

      // Asynchronous reset during a copy write cycle
      issue(2'b10, 8'd5, 8'd10, 6'd2, 8'h00);
      for (int c = 1; c <= 10; c++) begin
         @(negedge Clk);
         if (MemWrite) break;
      end
      chk("pre_reset_memwrite", int'(MemWrite), 1);
      #2 Clear_n = 1'b0;
      #1;
      chk("reset_memwrite", int'(MemWrite), 0);
      chk("reset_busy", int'(Busy), 0);
      chk("reset_mem_state", int'(Mem_State), 0);
      chk("reset_load_data", int'(Load_Data), 0);
      @(posedge Clk);
      @(negedge Clk);
      chk("reset_write_not_committed", int'(mem[10]), 8'h0a);
      Clear_n = 1'b1;

      vt[0] = '{2'b00, 8'd3, 8'd0, 6'd0, 8'h00, 2, 1'b0, 1, 0, 8'hf2};
      run_cmd(vt[0], cyc, err, nrd, nwr);
      chk("post_reset_load_cycle", cyc, 2);
      chk("post_reset_load_data", int'(Load_Data), 8'hf2);

      chk("protocol_violations", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
